// File: rtl/reg4_share_arbiter.sv
// rtl/reg4_share_arbiter.sv - round-robin sharing of one D-register (sync set/reset) among three requesters
module reg4_share_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic [2:0]         req,
  input  logic [3*WIDTH-1:0] din,
  output logic [2:0]         gnt,
  output logic [2:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK, HOLD} state_t;

  state_t     state, state_next;
  logic [1:0] w, w_next;
  logic [1:0] lw, lw_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] o0, o1, o2;
  logic [1:0] pick;
  logic       write;

  // Search order starts just after the last winner.
  always_comb begin
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    case (lw)
      2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (req[o0])      pick = o0;
    else if (req[o1]) pick = o1;
    else              pick = o2;
  end

  always_comb begin
    state_next = state;
    w_next     = w;
    lw_next    = lw;
    cnt_next   = cnt;
    write      = 1'b0;
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          w_next     = pick;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (req[w]) begin
          write      = 1'b1;
          lw_next    = w;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK: begin
        cnt_next   = 4'(HOLD_CYCLES);
        state_next = HOLD;
      end
      HOLD: begin
        if (cnt <= 4'd1) state_next = IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      w     <= 2'd0;
      lw    <= 2'd2;
      cnt   <= 4'd0;
      q     <= '0;
    end else begin
      state <= state_next;
      w     <= w_next;
      lw    <= lw_next;
      cnt   <= cnt_next;
      // set outranks a write, but the write is still acknowledged
      if (set)        q <= '1;
      else if (write) q <= din[w*WIDTH +: WIDTH];
    end
  end

  assign gnt  = (state == GRANT) ? (3'b001 << w) : 3'b000;
  assign ack  = (state == ACK)   ? (3'b001 << w) : 3'b000;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg4_share_arbiter.sv
// tb/tb_reg4_share_arbiter.sv - scoreboard bench for reg4_share_arbiter with a timeline reference model
module tb_reg4_share_arbiter;
  localparam int WIDTH = 4;
  localparam int HOLD  = 2;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               set   = 1'b0;
  logic [2:0]         req   = 3'b000;
  logic [3*WIDTH-1:0] din   = '0;
  logic [2:0]         gnt, ack;
  logic [WIDTH-1:0]   q;
  logic               busy;

  int checks = 0, failures = 0, cycle = 0;

  typedef struct {
    logic [2:0]       a;
    logic [WIDTH-1:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  reg4_share_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .set(set), .req(req), .din(din),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic ffail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Model: m_t counts edges since a winner was latched (-1 = idle).
  // Edge 1 after latching is the write decision; the service ends after 2+HOLD edges.
  int               m_t  = -1;
  int               m_w  = 0;
  int               m_lw = 2;
  logic [WIDTH-1:0] m_q  = '0;
  bit               m_wrote, m_found;
  int               m_idx;

  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      m_t  = -1;
      m_lw = 2;
      m_q  = '0;
      sb.delete();
    end else begin
      m_wrote = 0;
      if (m_t < 0) begin
        if (req != 3'b000) begin
          m_found = 0;
          for (int k = 1; k <= 3; k++) begin
            m_idx = (m_lw + k) % 3;
            if (!m_found && req[m_idx]) begin
              m_w     = m_idx;
              m_found = 1;
            end
          end
          m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t == 1) begin
          if (req[m_w]) begin
            m_q     = din[m_w*WIDTH +: WIDTH];
            m_lw    = m_w;
            m_wrote = 1;
          end else begin
            m_t = -1;
          end
        end else if (m_t == 2 + HOLD) begin
          m_t = -1;
        end
      end
      if (set) m_q = '1;
      if (m_wrote) sb.push_back('{a: 3'(1 << m_w), v: m_q});
    end
  end

  // Monitor: per-cycle outputs plus scoreboard pop on every ack.
  logic [2:0] exp_gnt;
  exp_t       e;
  always @(negedge clk) begin
    exp_gnt = (m_t == 0) ? 3'(1 << m_w) : 3'b000;
    chk("q", 32'(q), 32'(m_q));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(m_t >= 0));
    if (ack != 3'b000 || m_t == 1) begin
      if (sb.size() == 0) begin
        ffail("ack_unexpected");
      end else begin
        e = sb.pop_front();
        chk("sb_ack", 32'(ack), 32'(e.a));
        chk("sb_q", 32'(q), 32'(e.v));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one tick after the edge that closes the ACK cycle.
  task automatic wait_ack(input logic [2:0] ea, input logic [WIDTH-1:0] eq, input string nm, output int cyc);
    int n = 0;
    @(negedge clk);
    while (ack == 3'b000 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) ffail({nm, "_timeout"});
    else begin
      chk({nm, "_ack"}, 32'(ack), 32'(ea));
      chk({nm, "_q"}, 32'(q), 32'(eq));
    end
    cyc = cycle;
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) ffail("idle_timeout");
  endtask

  // Leaves the caller at the negedge inside the GRANT cycle.
  task automatic wait_gnt();
    int n = 0;
    @(negedge clk);
    while (gnt == 3'b000 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) ffail("gnt_timeout");
  endtask

  int c0, c1, c2, cx;

  initial begin
    // reset, then idle with no requests
    step();
    reset = 1'b0;
    repeat (5) begin
      step();
      chk("idle_q", 32'(q), 32'h0);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_ack", 32'(ack), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    // all three requesting: served 0,1,2 at the full service period
    reset = 1'b1;
    step();
    reset = 1'b0;
    din = {4'hC, 4'h6, 4'h3};
    req = 3'b111;
    wait_ack(3'b001, 4'h3, "rr0", c0);
    req[0] = 1'b0;
    wait_ack(3'b010, 4'h6, "rr1", c1);
    req[1] = 1'b0;
    wait_ack(3'b100, 4'hC, "rr2", c2);
    req = 3'b000;
    chk("spacing01", 32'(c1 - c0), 32'(3 + HOLD));
    chk("spacing12", 32'(c2 - c1), 32'(3 + HOLD));
    wait_idle();

    // bring lw to 0, then 3'b101 must go to requester 2 first
    din = {4'hA, 4'h0, 4'h5};
    req = 3'b001;
    wait_ack(3'b001, 4'h5, "lw0", cx);
    req = 3'b000;
    wait_idle();
    req = 3'b101;
    wait_ack(3'b100, 4'hA, "p101_2", cx);
    req[2] = 1'b0;
    wait_ack(3'b001, 4'h5, "p101_0", cx);
    req = 3'b000;
    wait_idle();

    // requester 1 drops during GRANT: abort with no write and no lw change
    din = {4'hA, 4'h7, 4'h5};
    req = 3'b010;
    wait_gnt();
    chk("abort_gnt", 32'(gnt), 32'h2);
    req = 3'b000;
    step();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_q", 32'(q), 32'h5);
    chk("abort_ack", 32'(ack), 32'h0);
    step();
    chk("abort_ack2", 32'(ack), 32'h0);
    req = 3'b110;
    wait_ack(3'b010, 4'h7, "abort_lw", cx);
    req = 3'b000;
    wait_idle();

    // set during HOLD, then set on the GRANT closing edge
    din = {4'h6, 4'h7, 4'h5};
    req = 3'b100;
    wait_ack(3'b100, 4'h6, "pre_set", cx);
    req = 3'b000;
    set = 1'b1;
    step();
    set = 1'b0;
    chk("set_hold_q", 32'(q), 32'hF);
    chk("set_hold_busy", 32'(busy), 32'h1);
    wait_idle();
    chk("set_hold_after", 32'(q), 32'hF);
    din = {4'h6, 4'h7, 4'h2};
    req = 3'b001;
    wait_gnt();
    set = 1'b1;
    step();
    set = 1'b0;
    chk("set_gnt_ack", 32'(ack), 32'h1);
    chk("set_gnt_q", 32'(q), 32'hF);
    req = 3'b000;
    wait_idle();

    // reset during HOLD clears q and restarts priority at requester 0
    din = {4'h6, 4'hD, 4'h9};
    req = 3'b010;
    wait_ack(3'b010, 4'hD, "pre_rst", cx);
    req = 3'b000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    req = 3'b111;
    wait_ack(3'b001, 4'h9, "rst_first", cx);
    req = 3'b000;
    wait_idle();

    // randomized traffic, aborts, sets and resets
    repeat (800) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (ack[i] || $urandom_range(0, 39) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          din[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req[i] = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
          din[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      set   = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    set   = 1'b0;
    req   = 3'b000;
    repeat (12) step();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
